// File: rtl/dps_utim64_pkg.sv
// Shared encodings for the UTIM64 bus arbiter: FSM states, RW codes, master IDs
// and the default error read data.
package dps_utim64_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'h0,
    ISSUE   = 2'h1,
    RD_WAIT = 2'h2
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } rw_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [31:0] DEF_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/dps_utim64_rr_arb2.sv
// Two-way round-robin grant with a registered last-grant pointer.
// On a tie, the master that was not granted last time wins.
module dps_utim64_rr_arb2
  import dps_utim64_pkg::*;
(
  input  logic       iCLOCK,
  input  logic       iRESET_SYNC,
  input  logic       iREQ0,
  input  logic       iREQ1,
  input  logic       iGRANT_EN,
  output logic [1:0] oGRANT,
  output logic       oOWNER
);

  logic last_grant;

  always_comb begin
    oOWNER = M0;
    oGRANT = '0;
    if (iREQ0 && iREQ1) begin
      oOWNER = (last_grant == M0) ? M1 : M0;
    end else if (iREQ1) begin
      oOWNER = M1;
    end
    if (iREQ0 || iREQ1) begin
      oGRANT = (oOWNER == M1) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      last_grant <= M1;
    end else if (iGRANT_EN && (iREQ0 || iREQ1)) begin
      last_grant <= oOWNER;
    end
  end

endmodule

// File: rtl/dps_utim64_bus_arbiter.sv
// Shares the UTIM64 timer register port between two masters: round-robin grant,
// one outstanding transaction, read responses routed back to the issuing master.
module dps_utim64_bus_arbiter
  import dps_utim64_pkg::*;
#(
  parameter logic [7:0]  P_TIMEOUT  = 8'd255,
  parameter logic [31:0] P_ERR_DATA = DEF_ERR_DATA
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iM0_REQ_VALID,
  output logic        oM0_REQ_BUSY,
  input  logic        iM0_REQ_RW,
  input  logic [4:0]  iM0_REQ_ADDR,
  input  logic [31:0] iM0_REQ_DATA,
  output logic        oM0_REQ_VALID,
  output logic [31:0] oM0_REQ_DATA,
  input  logic        iM1_REQ_VALID,
  output logic        oM1_REQ_BUSY,
  input  logic        iM1_REQ_RW,
  input  logic [4:0]  iM1_REQ_ADDR,
  input  logic [31:0] iM1_REQ_DATA,
  output logic        oM1_REQ_VALID,
  output logic [31:0] oM1_REQ_DATA,
  output logic        oTIM_REQ_VALID,
  input  logic        iTIM_REQ_BUSY,
  output logic        oTIM_REQ_RW,
  output logic [4:0]  oTIM_REQ_ADDR,
  output logic [31:0] oTIM_REQ_DATA,
  input  logic        iTIM_REQ_VALID,
  input  logic [31:0] iTIM_REQ_DATA,
  output logic        oTIMEOUT_ERR
);

  state_t      state;
  logic        cmd_owner;
  logic        cmd_rw;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [7:0]  cnt;

  logic        busy;
  logic        accept;
  logic [1:0]  grant;
  logic        grant_id;
  logic        rd_done;
  logic [31:0] rd_data;

  assign busy         = (state != IDLE) || iTIM_REQ_BUSY;
  assign oM0_REQ_BUSY = busy;
  assign oM1_REQ_BUSY = busy;
  assign accept       = !busy && (grant != 2'b00);

  assign oTIM_REQ_RW   = cmd_rw;
  assign oTIM_REQ_ADDR = cmd_addr;
  assign oTIM_REQ_DATA = cmd_data;

  // A real response takes priority over a timeout landing in the same cycle.
  assign rd_done = iTIM_REQ_VALID || (cnt >= P_TIMEOUT);
  assign rd_data = iTIM_REQ_VALID ? iTIM_REQ_DATA : P_ERR_DATA;

  dps_utim64_rr_arb2 u_arb (
    .iCLOCK      (iCLOCK),
    .iRESET_SYNC (iRESET_SYNC),
    .iREQ0       (iM0_REQ_VALID),
    .iREQ1       (iM1_REQ_VALID),
    .iGRANT_EN   (accept),
    .oGRANT      (grant),
    .oOWNER      (grant_id)
  );

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state          <= IDLE;
      cmd_owner      <= M0;
      cmd_rw         <= 1'b0;
      cmd_addr       <= '0;
      cmd_data       <= '0;
      cnt            <= '0;
      oTIM_REQ_VALID <= 1'b0;
      oM0_REQ_VALID  <= 1'b0;
      oM1_REQ_VALID  <= 1'b0;
      oM0_REQ_DATA   <= '0;
      oM1_REQ_DATA   <= '0;
      oTIMEOUT_ERR   <= 1'b0;
    end else begin
      oM0_REQ_VALID <= 1'b0;
      oM1_REQ_VALID <= 1'b0;
      oM0_REQ_DATA  <= '0;
      oM1_REQ_DATA  <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_owner      <= grant_id;
            cmd_rw         <= grant[1] ? iM1_REQ_RW   : iM0_REQ_RW;
            cmd_addr       <= grant[1] ? iM1_REQ_ADDR : iM0_REQ_ADDR;
            cmd_data       <= grant[1] ? iM1_REQ_DATA : iM0_REQ_DATA;
            oTIM_REQ_VALID <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (!iTIM_REQ_BUSY) begin
            oTIM_REQ_VALID <= 1'b0;
            cnt            <= '0;
            state          <= (cmd_rw == WRITE) ? IDLE : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_done) begin
            if (cmd_owner == M1) begin
              oM1_REQ_VALID <= 1'b1;
              oM1_REQ_DATA  <= rd_data;
            end else begin
              oM0_REQ_VALID <= 1'b1;
              oM0_REQ_DATA  <= rd_data;
            end
            if (!iTIM_REQ_VALID) begin
              oTIMEOUT_ERR <= 1'b1;
            end
            state <= IDLE;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dps_utim64_bus_arbiter.sv
// Scoreboard bench for dps_utim64_bus_arbiter: directed stimulus pushes expected
// downstream commands and master responses; a monitor pops and compares them.
module tb_dps_utim64_bus_arbiter;

  typedef struct packed {
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] data;
  } cmd_t;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic        m0_rw = 1'b0, m1_rw = 1'b0;
  logic [4:0]  m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_busy, m1_busy, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        tim_valid, tim_rw;
  logic [4:0]  tim_addr;
  logic [31:0] tim_data;
  logic        tim_busy = 1'b0;
  logic        tim_rvalid = 1'b0;
  logic [31:0] tim_rdata = '0;
  logic        timeout_err;

  cmd_t tim_q[$];
  rsp_t rsp_q[$];
  cmd_t exp_cmd;
  rsp_t exp_rsp;
  int   checks = 0;
  int   errors = 0;

  dps_utim64_bus_arbiter #(.P_TIMEOUT(8'd4)) dut (
    .iCLOCK         (clk),
    .iRESET_SYNC    (rst),
    .iM0_REQ_VALID  (m0_valid),
    .oM0_REQ_BUSY   (m0_busy),
    .iM0_REQ_RW     (m0_rw),
    .iM0_REQ_ADDR   (m0_addr),
    .iM0_REQ_DATA   (m0_wdata),
    .oM0_REQ_VALID  (m0_rvalid),
    .oM0_REQ_DATA   (m0_rdata),
    .iM1_REQ_VALID  (m1_valid),
    .oM1_REQ_BUSY   (m1_busy),
    .iM1_REQ_RW     (m1_rw),
    .iM1_REQ_ADDR   (m1_addr),
    .iM1_REQ_DATA   (m1_wdata),
    .oM1_REQ_VALID  (m1_rvalid),
    .oM1_REQ_DATA   (m1_rdata),
    .oTIM_REQ_VALID (tim_valid),
    .iTIM_REQ_BUSY  (tim_busy),
    .oTIM_REQ_RW    (tim_rw),
    .oTIM_REQ_ADDR  (tim_addr),
    .oTIM_REQ_DATA  (tim_data),
    .iTIM_REQ_VALID (tim_rvalid),
    .iTIM_REQ_DATA  (tim_rdata),
    .oTIMEOUT_ERR   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a request and holds it until the arbiter samples it with busy low.
  task automatic do_req(input logic v0, input logic v1, input logic rw0, input logic rw1,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
    int n = 0;
    @(posedge clk); #1;
    m0_valid = v0; m0_rw = rw0; m0_addr = a0; m0_wdata = d0;
    m1_valid = v1; m1_rw = rw1; m1_addr = a1; m1_wdata = d1;
    forever begin
      @(negedge clk);
      if (!m0_busy) break;
      n++;
      if (n > 200) begin
        fail_now("accept_timeout", n);
        break;
      end
    end
    @(posedge clk); #1;
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  // Returns at the negedge preceding the downstream handshake edge.
  task automatic wait_issue();
    int n = 0;
    forever begin
      @(negedge clk);
      if (tim_valid && !tim_busy) break;
      n++;
      if (n > 50) begin
        fail_now("issue_timeout", n);
        break;
      end
    end
  endtask

  task automatic tim_pulse(input logic [31:0] d);
    tim_rvalid = 1'b1; tim_rdata = d;
    @(posedge clk); #1;
    tim_rvalid = 1'b0; tim_rdata = '0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tim_valid && !tim_busy) begin
          if (tim_q.size() == 0) fail_now("tim_unexpected", {tim_rw, tim_addr, tim_data});
          else begin
            exp_cmd = tim_q.pop_front();
            chk("tim_cmd", {tim_rw, tim_addr, tim_data}, exp_cmd);
          end
        end
        if (m0_rvalid && m1_rvalid) begin
          fail_now("both_valid", {m0_rdata, m1_rdata});
        end else if (m0_rvalid || m1_rvalid) begin
          if (rsp_q.size() == 0) fail_now("rsp_unexpected", {m1_rvalid, m1_rdata | m0_rdata});
          else begin
            exp_rsp = rsp_q.pop_front();
            chk("rsp", {m1_rvalid, (m1_rvalid ? m1_rdata : m0_rdata)}, exp_rsp);
            chk("rsp_other_data", (m1_rvalid ? m0_rdata : m1_rdata), 0);
          end
        end else begin
          chk("idle_rdata", {m0_rdata, m1_rdata}, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {m0_busy, m1_busy}, 0);
    chk("rst_tim", {tim_valid, tim_rw, tim_addr, tim_data}, 0);
    chk("rst_rsp", {m0_rvalid, m1_rvalid, timeout_err}, 0);

    // M0 write, downstream idle
    tim_q.push_back('{1'b1, 5'h02, 32'h1234_5678});
    do_req(1, 0, 1, 0, 5'h02, 5'h00, 32'h1234_5678, 0);
    chk("wr_issue_t1", tim_valid, 1);
    settle(1);
    chk("wr_idle_t2", {m0_busy, tim_valid}, 0);

    // M1 read, response three cycles after issue
    tim_q.push_back('{1'b0, 5'h11, 32'h0});
    rsp_q.push_back('{1'b1, 32'hCAFE_0001});
    do_req(0, 1, 0, 0, 5'h00, 5'h11, 0, 0);
    wait_issue();
    repeat (4) @(posedge clk);
    #1 tim_pulse(32'hCAFE_0001);
    settle(3);

    // Three simultaneous write rounds: M0, M1, M0
    for (int i = 0; i < 3; i++) begin
      if (i == 1) tim_q.push_back('{1'b1, 5'h08, 32'hB000_0000 + 32'(i)});
      else        tim_q.push_back('{1'b1, 5'h04, 32'hA000_0000 + 32'(i)});
      do_req(1, 1, 1, 1, 5'h04, 5'h08, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
    end
    settle(3);

    // Downstream busy for 5 cycles during ISSUE
    tim_q.push_back('{1'b1, 5'h1F, 32'h5A5A_A5A5});
    do_req(0, 1, 0, 1, 5'h00, 5'h1F, 0, 32'h5A5A_A5A5);
    tim_busy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_cmd", {tim_valid, tim_rw, tim_addr, tim_data}, {1'b1, 1'b1, 5'h1F, 32'h5A5A_A5A5});
    end
    @(posedge clk); #1 tim_busy = 1'b0;
    settle(3);

    // Stray downstream response while idle
    tim_pulse(32'h0000_0077);
    settle(3);

    // Response arriving in the same cycle the counter hits P_TIMEOUT
    tim_q.push_back('{1'b0, 5'h04, 32'h0});
    rsp_q.push_back('{1'b1, 32'h1357_9BDF});
    do_req(0, 1, 0, 0, 5'h00, 5'h04, 0, 0);
    wait_issue();
    repeat (5) @(posedge clk);
    #1 tim_pulse(32'h1357_9BDF);
    settle(3);
    chk("race_no_err", timeout_err, 0);

    // Read timeout
    tim_q.push_back('{1'b0, 5'h03, 32'h0});
    rsp_q.push_back('{1'b0, 32'hFFFF_FFFF});
    do_req(1, 0, 0, 0, 5'h03, 5'h00, 0, 0);
    wait_issue();
    settle(8);
    chk("timeout_err_set", timeout_err, 1);
    settle(5);
    chk("timeout_err_sticky", timeout_err, 1);

    // Reset during RD_WAIT after an M0 grant
    tim_q.push_back('{1'b0, 5'h07, 32'h0});
    do_req(1, 0, 0, 0, 5'h07, 5'h00, 0, 0);
    wait_issue();
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    tim_pulse(32'hDEAD_BEEF);
    @(negedge clk);
    chk("rst_mid_busy", {m0_busy, m1_busy}, 0);
    chk("rst_mid_err", timeout_err, 0);
    settle(2);
    tim_q.push_back('{1'b1, 5'h09, 32'hC0DE_0000});
    do_req(1, 1, 1, 1, 5'h09, 5'h0A, 32'hC0DE_0000, 32'hC0DE_0001);
    settle(4);

    chk("tim_q_drained", tim_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
